// File: rtl/speck_uart_pkg.sv
// rtl/speck_uart_pkg.sv - shared types and constants for the Speck/UART byte path
// Purpose: FSM state encoding and width constants used by speck_block_tx and its interface.
// Ports: none (package).
package speck_uart_pkg;

  localparam int SPECK_BLOCK_BYTES = 8;
  localparam int BYTE_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/speck_block_tx_if.sv
// rtl/speck_block_tx_if.sv - block-in / byte-out handshake bundle for speck_block_tx
// Purpose: groups the block handshake, the uart_tx byte strobe and the status flags.
// Ports (signals):
//   blk_data[8*BLOCK_BYTES], blk_valid, blk_ready  - block offer/accept
//   tx_data[8], tx_valid, tx_busy                  - byte strobe to uart_tx and its busy flag
//   sending, done                                  - block-level status
// Modports: master = the serializer, slave = the surrounding logic / uart_tx side.
interface speck_block_tx_if #(
  parameter int BLOCK_BYTES = speck_uart_pkg::SPECK_BLOCK_BYTES
);

  logic [8*BLOCK_BYTES-1:0] blk_data;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_busy;
  logic                     sending;
  logic                     done;

  modport master (
    input  blk_data, blk_valid, tx_busy,
    output blk_ready, tx_data, tx_valid, sending, done
  );

  modport slave (
    output blk_data, blk_valid, tx_busy,
    input  blk_ready, tx_data, tx_valid, sending, done
  );

endinterface

// File: rtl/speck_block_tx.sv
// rtl/speck_block_tx.sv - serializes one Speck block into bytes for uart_tx
// Purpose: accepts a whole block with one handshake, then strobes its bytes one at a
//   time into uart_tx, pacing on tx_busy; optionally appends an XOR checksum byte.
// Optional feature macro: SPECK_BLOCK_TX_CHECKSUM_EN (append checksum byte after the block).
// Parameters: BLOCK_BYTES (2..16), MSB_FIRST (1 = top byte first, 0 = bottom byte first).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - speck_block_tx_if.master (block handshake, byte strobe, busy, status)
module speck_block_tx
  import speck_uart_pkg::*;
#(
  parameter int BLOCK_BYTES = SPECK_BLOCK_BYTES,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  speck_block_tx_if.master  bus
);

  localparam int               DW    = BYTE_W * BLOCK_BYTES;
  localparam int               CNT_W = $clog2(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_BYTES - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;   // keeps blk_ready low until the first edge after reset
  logic [BYTE_W-1:0] tx_data_q; // last strobed byte, held while the line is busy
  logic [BYTE_W-1:0] cur_byte;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_valid;
  logic              accept;
  logic              more_bytes;
  logic              advance;
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic              csum_sent_q;
`endif

  assign cur_byte   = MSB_FIRST ? shreg_q[DW-1 -: BYTE_W] : shreg_q[BYTE_W-1:0];
  assign accept     = (state_q == ST_IDLE) && armed_q && bus.blk_valid;
  assign more_bytes = (cnt_q < LAST);
  assign advance    = (state_q == ST_WAIT_LO) && !bus.tx_busy && more_bytes;

  // The strobe is decoded directly from the state so a byte goes out in the cycle the
  // FSM enters SEND/CSUM; leaving those states next edge limits it to one cycle.
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
  assign tx_valid = ((state_q == ST_SEND) || (state_q == ST_CSUM)) && !bus.tx_busy;
`else
  assign tx_valid = (state_q == ST_SEND) && !bus.tx_busy;
`endif

  always_comb begin
    tx_byte = tx_data_q;
    case (state_q)
      ST_SEND: tx_byte = cur_byte;
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
      ST_CSUM: tx_byte = csum_q;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SEND;
      ST_SEND:    if (!bus.tx_busy) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (bus.tx_busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!bus.tx_busy) begin
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
          if (csum_sent_q)     state_d = ST_DONE;
          else if (more_bytes) state_d = ST_SEND;
          else                 state_d = ST_CSUM;
`else
          if (more_bytes) state_d = ST_SEND;
          else            state_d = ST_DONE;
`endif
        end
      end
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
      ST_CSUM:    if (!bus.tx_busy) state_d = ST_WAIT_HI;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      tx_data_q   <= '0;
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        shreg_q     <= bus.blk_data;
        cnt_q       <= '0;
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
        csum_q      <= '0;
        csum_sent_q <= 1'b0;
`endif
      end else if (advance) begin
        shreg_q <= MSB_FIRST ? (shreg_q << BYTE_W) : (shreg_q >> BYTE_W);
        cnt_q   <= cnt_q + 1'b1;
      end
      if (tx_valid) tx_data_q <= tx_byte;
`ifdef SPECK_BLOCK_TX_CHECKSUM_EN
      if (tx_valid && (state_q == ST_SEND)) csum_q <= csum_q ^ cur_byte;
      if (tx_valid && (state_q == ST_CSUM)) csum_sent_q <= 1'b1;
`endif
    end
  end

  assign bus.blk_ready = armed_q && (state_q == ST_IDLE);
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_byte;
  assign bus.sending   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);

endmodule
